adc_mavg_filter: RTL and testbench

//  Parametrised multi-channel boxcar (moving-average) filter for ADC sample streams.

---
 rtl/adc_mavg_filter.sv | 77 +++++++
 tb/tb_adc_mavg_filter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adc_mavg_filter.sv
// Multi-channel boxcar (moving-average) filter for ADC sample streams.
// Each channel keeps a circular history and a running sum; the write pointer is shared.
module adc_mavg_filter #(
  parameter int N          = 14,
  parameter int CH         = 2,
  parameter int LOG2_DEPTH = 3,
  parameter int ROUND      = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            bypass,
  input  logic            in_valid,
  input  logic [CH*N-1:0] adc_data,
  output logic            out_valid,
  output logic [CH*N-1:0] filtered_data,
  output logic            primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = N + LOG2_DEPTH;
  localparam int WPW   = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int FW    = LOG2_DEPTH + 1;
  localparam logic [SW:0] RND_ADD = (ROUND != 0) ? (SW+1)'(DEPTH / 2) : '0;
  localparam logic [SW:0] MAXW    = {{(LOG2_DEPTH+1){1'b0}}, {N{1'b1}}};

  logic [WPW-1:0] wp;
  logic [FW-1:0]  fill;
  logic [N-1:0]   hist   [CH][DEPTH];
  logic [SW-1:0]  sum    [CH];
  logic [SW-1:0]  sum_n  [CH];
  logic [SW:0]    rnd    [CH];
  logic [SW:0]    rnd_sh [CH];
  logic [N-1:0]   avg    [CH];
  logic           accept;

  assign accept = in_valid & ~clear;

  // Running-sum update: the sample leaving the window is the one about to be overwritten.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum_n[c]  = sum[c] + SW'(adc_data[c*N +: N]) - SW'(hist[c][wp]);
      rnd[c]    = {1'b0, sum_n[c]} + RND_ADD;
      rnd_sh[c] = rnd[c] >> LOG2_DEPTH;
      avg[c]    = (rnd_sh[c] > MAXW) ? {N{1'b1}} : rnd_sh[c][N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp            <= '0;
      fill          <= '0;
      primed        <= 1'b0;
      out_valid     <= 1'b0;
      filtered_data <= '0;
      for (int c = 0; c < CH; c++) begin
        sum[c] <= '0;
        for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
      end
    end else begin
      out_valid <= accept;
      if (accept) begin
        for (int c = 0; c < CH; c++) begin
          hist[c][wp] <= adc_data[c*N +: N];
          sum[c]      <= sum_n[c];
          filtered_data[c*N +: N] <= bypass ? adc_data[c*N +: N] : avg[c];
        end
        if (wp == WPW'(DEPTH - 1)) wp <= '0;
        else                       wp <= wp + 1'b1;
        // primed rises together with the out_valid of the DEPTH-th accept.
        if (fill != FW'(DEPTH)) fill <= fill + 1'b1;
        if (fill >= FW'(DEPTH - 1)) primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_mavg_filter.sv
// Directed bench for adc_mavg_filter: window model, expected-result queues and
// two instances (truncating and rounding) fed with identical stimulus.
module tb_adc_mavg_filter;

  localparam int N  = 14;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int W  = CH * N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         bypass = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] adc_data = '0;
  logic         out_valid0, out_valid1, primed0, primed1;
  logic [W-1:0] data0, data1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] last0, last1;
  int win [CH][D];
  int fill_m;

  always #5 clk = ~clk;

  adc_mavg_filter #(.N(N), .CH(CH), .LOG2_DEPTH(2), .ROUND(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .bypass(bypass), .in_valid(in_valid),
    .adc_data(adc_data), .out_valid(out_valid0), .filtered_data(data0), .primed(primed0));

  adc_mavg_filter #(.N(N), .CH(CH), .LOG2_DEPTH(2), .ROUND(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .bypass(bypass), .in_valid(in_valid),
    .adc_data(adc_data), .out_valid(out_valid1), .filtered_data(data1), .primed(primed1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < D; k++) win[c][k] = 0;
    fill_m = 0;
    exp_q.delete();
    exp1_q.delete();
    last0 = '0;
    last1 = '0;
  endtask

  // Plain average of the last D samples, computed by division.
  function automatic logic [N-1:0] win_avg(input int c, input int rnd);
    int s, v;
    s = 0;
    for (int k = 0; k < D; k++) s += win[c][k];
    v = (s + rnd) / D;
    if (v > 16383) v = 16383;
    return N'(v);
  endfunction

  task automatic check_outputs(input string tag, input logic exp_valid);
    check({tag, " valid0"}, 32'(out_valid0), 32'(exp_valid));
    check({tag, " valid1"}, 32'(out_valid1), 32'(exp_valid));
    check({tag, " primed0"}, 32'(primed0), 32'(fill_m >= D));
    check({tag, " primed1"}, 32'(primed1), 32'(fill_m >= D));
    if (out_valid0) begin
      if (exp_q.size() == 0) check({tag, " q0 empty"}, 32'd1, 32'd0);
      else last0 = exp_q.pop_front();
    end
    if (out_valid1) begin
      if (exp1_q.size() == 0) check({tag, " q1 empty"}, 32'd1, 32'd0);
      else last1 = exp1_q.pop_front();
    end
    check({tag, " ch0"}, 32'(data0[0 +: N]), 32'(last0[0 +: N]));
    check({tag, " ch1"}, 32'(data0[N +: N]), 32'(last0[N +: N]));
    check({tag, " r ch0"}, 32'(data1[0 +: N]), 32'(last1[0 +: N]));
    check({tag, " r ch1"}, 32'(data1[N +: N]), 32'(last1[N +: N]));
  endtask

  task automatic step(input string tag, input logic v, input logic cl, input logic by,
                      input int d0, input int d1);
    logic         acc;
    logic [W-1:0] e0, e1;
    adc_data = {N'(d1), N'(d0)};
    in_valid = v;
    clear    = cl;
    bypass   = by;
    acc = v && !cl;
    if (cl) begin
      model_clear();
    end else if (acc) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = D - 1; k > 0; k--) win[c][k] = win[c][k-1];
        win[c][0] = (c == 0) ? d0 : d1;
      end
      if (fill_m < D) fill_m++;
      e0 = by ? adc_data : {win_avg(1, 0), win_avg(0, 0)};
      e1 = by ? adc_data : {win_avg(1, D / 2), win_avg(0, D / 2)};
      exp_q.push_back(e0);
      exp1_q.push_back(e1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    check_outputs(tag, acc);
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b1;
    in_valid = 1'b1;
    adc_data = {N'(77), N'(99)};
    model_clear();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check_outputs(tag, 1'b0);
  endtask

  initial begin
    model_clear();
    do_reset("reset");

    // Warm-up ramp: 25,50,75,100 with primed on the fourth output.
    for (int i = 0; i < 4; i++) step("warmup", 1'b1, 1'b0, 1'b0, 100, 0);
    // Step to 200 across two pointer wraps: 125,150,175,200,200.
    for (int i = 0; i < 5; i++) step("stepwrap", 1'b1, 1'b0, 1'b0, 200, 0);

    // Full-scale on one channel only, then swap.
    for (int i = 0; i < 8; i++) step("fullscale", 1'b1, 1'b0, 1'b0, 16383, 0);
    for (int i = 0; i < 5; i++) step("swap", 1'b1, 1'b0, 1'b0, 0, 16383);

    // Alternate-cycle accepts with random data; output holds between pulses.
    for (int i = 0; i < 6; i++) begin
      step("gap acc", 1'b1, 1'b0, 1'b0, int'($urandom_range(0, 16383)),
           int'($urandom_range(0, 16383)));
      step("gap idle", 1'b0, 1'b0, 1'b0, 5, 5);
    end
    step("clear", 1'b1, 1'b1, 1'b0, 1234, 4321);
    step("after clear", 1'b1, 1'b0, 1'b0, 40, 0);

    // Bypass then back to averaging without a transient.
    for (int i = 0; i < 4; i++) step("bypass", 1'b1, 1'b0, 1'b1, 8, 8);
    step("unbypass", 1'b1, 1'b0, 1'b0, 8, 8);

    // Rounding: 1,0,0,0 then 2,2 from clear.
    step("rnd clear", 1'b0, 1'b1, 1'b0, 0, 0);
    step("rnd a", 1'b1, 1'b0, 1'b0, 1, 1);
    for (int i = 0; i < 3; i++) step("rnd b", 1'b1, 1'b0, 1'b0, 0, 0);
    step("rnd clear2", 1'b0, 1'b1, 1'b0, 0, 0);
    step("rnd c", 1'b1, 1'b0, 1'b0, 2, 2);
    step("rnd d", 1'b1, 1'b0, 1'b0, 2, 2);
    check("rnd const ch0", 32'(data1[0 +: N]), 32'd1);

    // Random back-to-back stream, then reset mid-stream.
    for (int i = 0; i < 20; i++)
      step("random", 1'b1, 1'b0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
    do_reset("midreset");
    step("post reset", 1'b1, 1'b0, 1'b0, 400, 800);
    check("post reset const", 32'(data0[0 +: N]), 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
